// File: rtl/running_light_pkg.sv
// Shared types and constants for the running-light controller.
//   state_t : run/pause FSM encoding
//   SPD_MAX : highest speed index; the next speed press wraps to 0
package running_light_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [1:0] SPD_MAX = 2'd3;

endpackage

// File: rtl/edge_detect.sv
// Two-flop key sampler that turns a debounced active-low key into a
// one-cycle press pulse on the falling edge.
//   clk50m      : system clock
//   rst_n       : asynchronous active-low reset
//   key_n       : debounced key, low while pressed
//   fallingedge : high for one cycle after the key is first sampled low
module edge_detect (
    input  logic clk50m,
    input  logic rst_n,
    input  logic key_n,
    output logic fallingedge
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = key_n;
        s2_d = s1_q;
    end

    // Reset to the released level so no pulse appears when reset lifts.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign fallingedge = s2_q & ~s1_q;

endmodule

// File: rtl/running_light_ctrl.sv
// Running-light sequencer. Converts four keys into press pulses, runs an
// IDLE/RUN/PAUSE FSM that steps an address counter through the pattern
// memory at BASE_TICKS << speed cycles per step, and latches each returned
// pattern word onto the LEDs.
//   clk50m, rst_n          : clock, asynchronous active-low reset
//   key_run_n/dir_n/spd_n  : start/stop, direction toggle, speed cycle keys
//   key_clr_n              : clear key, returns to IDLE
//   mem_rd, mem_addr       : one-cycle read strobe and address to memory
//   mem_rdata              : pattern word, valid one cycle after mem_rd
//   led                    : LED drive
//   running, dir_down, speed : status outputs
module running_light_ctrl
    import running_light_pkg::*;
#(
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned DATA_W     = 10,
    parameter int unsigned LAST_ADDR  = 15,
    parameter int unsigned BASE_TICKS = 2_500_000,
    parameter int unsigned CNT_W      = 26
) (
    input  logic              clk50m,
    input  logic              rst_n,
    input  logic              key_run_n,
    input  logic              key_dir_n,
    input  logic              key_spd_n,
    input  logic              key_clr_n,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] led,
    output logic              running,
    output logic              dir_down,
    output logic [1:0]        speed
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    logic run_p, dir_p, spd_p, clr_p;

    edge_detect u_run (.clk50m(clk50m), .rst_n(rst_n), .key_n(key_run_n), .fallingedge(run_p));
    edge_detect u_dir (.clk50m(clk50m), .rst_n(rst_n), .key_n(key_dir_n), .fallingedge(dir_p));
    edge_detect u_spd (.clk50m(clk50m), .rst_n(rst_n), .key_n(key_spd_n), .fallingedge(spd_p));
    edge_detect u_clr (.clk50m(clk50m), .rst_n(rst_n), .key_n(key_clr_n), .fallingedge(clr_p));

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              rd_q,    rd_d;
    logic              pend_q,  pend_d;
    logic [DATA_W-1:0] led_q,   led_d;
    logic              dir_q,   dir_d;
    logic [1:0]        spd_q,   spd_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    logic [CNT_W-1:0]  period_m1;
    logic              tick;
    logic [ADDR_W-1:0] step_addr;

    always_comb begin
        period_m1 = (CNT_W'(BASE_TICKS) << spd_q) - CNT_W'(1);
        tick      = (state_q == ST_RUN) && (cnt_q == period_m1);

        if (dir_q) step_addr = (addr_q == '0)   ? LAST : addr_q - ADDR_W'(1);
        else       step_addr = (addr_q == LAST) ? '0   : addr_q + ADDR_W'(1);
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rd_d    = 1'b0;
        pend_d  = rd_q;
        led_d   = led_q;
        dir_d   = dir_q ^ dir_p;
        spd_d   = spd_q;
        cnt_d   = cnt_q;

        if (pend_q) led_d = mem_rdata;

        // clr > run > tick; dir/spd are handled independently around this.
        if (clr_p) begin
            state_d = ST_IDLE;
            addr_d  = '0;
            led_d   = '0;
            cnt_d   = '0;
            pend_d  = 1'b0;
        end else if (run_p) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RUN;
                    addr_d  = '0;
                    rd_d    = 1'b1;
                    cnt_d   = '0;
                end
                // A pause landing on a tick still wraps the count, so the
                // resumed step comes a full period later.
                ST_RUN: begin
                    state_d = ST_PAUSE;
                    cnt_d   = tick ? '0 : cnt_q;
                end
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end else if (state_q == ST_RUN) begin
            if (tick) begin
                cnt_d  = '0;
                addr_d = step_addr;
                rd_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (spd_p) begin
            spd_d = (spd_q == SPD_MAX) ? 2'd0 : spd_q + 2'd1;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            pend_q  <= 1'b0;
            led_q   <= '0;
            dir_q   <= 1'b0;
            spd_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            pend_q  <= pend_d;
            led_q   <= led_d;
            dir_q   <= dir_d;
            spd_q   <= spd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_rd   = rd_q;
    assign mem_addr = addr_q;
    assign led      = led_q;
    assign running  = (state_q == ST_RUN);
    assign dir_down = dir_q;
    assign speed    = spd_q;

endmodule

// File: tb/tb_running_light_ctrl.sv
// Directed bench for running_light_ctrl with small parameters. Expected
// memory reads (address, cycle, whether to check the LED) are queued as
// stimulus is applied; a negedge monitor pops and compares each read.
module tb_running_light_ctrl;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 8;

    logic              clk50m = 1'b0;
    logic              rst_n  = 1'b0;
    logic              key_run_n = 1'b1;
    logic              key_dir_n = 1'b1;
    logic              key_spd_n = 1'b1;
    logic              key_clr_n = 1'b1;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] led;
    logic              running;
    logic              dir_down;
    logic [1:0]        speed;

    running_light_ctrl #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .LAST_ADDR (3),
        .BASE_TICKS(4),
        .CNT_W     (6)
    ) u_dut (
        .clk50m   (clk50m),
        .rst_n    (rst_n),
        .key_run_n(key_run_n),
        .key_dir_n(key_dir_n),
        .key_spd_n(key_spd_n),
        .key_clr_n(key_clr_n),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .led      (led),
        .running  (running),
        .dir_down (dir_down),
        .speed    (speed)
    );

    always #10 clk50m = ~clk50m;

    // Pattern memory model: word A0+addr, one cycle after the strobe.
    always @(posedge clk50m or negedge rst_n) begin
        if (!rst_n)      mem_rdata <= '0;
        else if (mem_rd) mem_rdata <= 8'hA0 + {6'b0, mem_addr};
    end

    int unsigned cyc = 0;
    always @(posedge clk50m) cyc <= cyc + 1;

    typedef struct {
        int unsigned addr;
        int unsigned at;
        bit          chk_led;
    } rd_exp_t;

    rd_exp_t     exp_q[$];
    rd_exp_t     cur;
    int unsigned checks = 0;
    int unsigned passed = 0;
    int          led_due = -1;
    int unsigned led_exp = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic expect_rd(input int unsigned addr, input int unsigned at, input bit chk_led);
        rd_exp_t e;
        e.addr    = addr;
        e.at      = at;
        e.chk_led = chk_led;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int unsigned t);
        while (cyc < t) begin
            @(posedge clk50m);
            #1;
        end
    endtask

    always @(negedge clk50m) begin
        if (rst_n) begin
            if (mem_rd) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rd_cycle", cyc, 32'hFFFF_FFFF);
                end else begin
                    cur = exp_q.pop_front();
                    check("rd_addr", 32'(mem_addr), cur.addr);
                    check("rd_cycle", cyc, cur.at);
                    if (cur.chk_led) begin
                        led_due = int'(cyc) + 2;
                        led_exp = 32'hA0 + cur.addr;
                    end
                end
            end
            if (led_due >= 0 && int'(cyc) == led_due) begin
                check("led_after_rd", 32'(led), led_exp);
                led_due = -1;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: observed timeout expected finish, %0d/%0d checks passed", passed, checks);
        $fatal(1, "timeout");
    end

    int unsigned c0;

    initial begin
        // 1. reset and idle with keys released
        repeat (3) @(posedge clk50m);
        #1;
        check("rst_led", 32'(led), 0);
        check("rst_running", 32'(running), 0);
        check("rst_mem_rd", 32'(mem_rd), 0);
        rst_n = 1'b1;
        repeat (50) @(posedge clk50m);
        #1;
        check("idle_led", 32'(led), 0);
        check("idle_running", 32'(running), 0);
        check("idle_addr", 32'(mem_addr), 0);
        check("idle_speed", 32'(speed), 0);
        check("idle_dir", 32'(dir_down), 0);

        // 2. run press held for 20 cycles
        c0 = cyc;
        key_run_n = 1'b0;
        expect_rd(0, c0 + 2,  1'b1);
        expect_rd(1, c0 + 6,  1'b1);
        expect_rd(2, c0 + 10, 1'b1);
        expect_rd(3, c0 + 14, 1'b1);
        expect_rd(0, c0 + 18, 1'b1);
        expect_rd(1, c0 + 22, 1'b1);
        expect_rd(2, c0 + 26, 1'b1);
        wait_until(c0 + 3);
        check("run_running", 32'(running), 1);
        wait_until(c0 + 20);
        check("run_held_running", 32'(running), 1);
        key_run_n = 1'b1;

        // 3. direction toggle while at address 2
        wait_until(c0 + 26);
        expect_rd(1, c0 + 30, 1'b1);
        expect_rd(0, c0 + 34, 1'b1);
        expect_rd(3, c0 + 38, 1'b1);
        key_dir_n = 1'b0;
        wait_until(c0 + 29);
        key_dir_n = 1'b1;
        check("dir_toggled", 32'(dir_down), 1);
        check("dir_no_immediate_step", 32'(mem_addr), 2);

        // 4. speed presses: 0->1->2 (16-cycle steps), then 3->0
        wait_until(c0 + 39);
        key_spd_n = 1'b0;
        wait_until(c0 + 42);
        key_spd_n = 1'b1;
        check("speed_1", 32'(speed), 1);
        wait_until(c0 + 45);
        expect_rd(2, c0 + 63, 1'b1);
        key_spd_n = 1'b0;
        wait_until(c0 + 48);
        key_spd_n = 1'b1;
        check("speed_2", 32'(speed), 2);
        wait_until(c0 + 64);
        key_spd_n = 1'b0;
        wait_until(c0 + 67);
        key_spd_n = 1'b1;
        check("speed_3", 32'(speed), 3);
        wait_until(c0 + 70);
        expect_rd(1, c0 + 76, 1'b1);
        key_spd_n = 1'b0;
        wait_until(c0 + 73);
        key_spd_n = 1'b1;
        check("speed_wrap_0", 32'(speed), 0);

        // 5. run press landing on the tick at address 1, then resume
        wait_until(c0 + 78);
        key_run_n = 1'b0;
        wait_until(c0 + 81);
        key_run_n = 1'b1;
        check("pause_running", 32'(running), 0);
        check("pause_addr", 32'(mem_addr), 1);
        wait_until(c0 + 84);
        expect_rd(0, c0 + 90, 1'b1);
        expect_rd(3, c0 + 94, 1'b1);
        expect_rd(2, c0 + 98, 1'b0);
        key_run_n = 1'b0;
        wait_until(c0 + 87);
        key_run_n = 1'b1;
        check("resume_running", 32'(running), 1);
        check("resume_no_step", 32'(mem_addr), 1);

        // 6. clear in the read-return cycle
        wait_until(c0 + 98);
        key_clr_n = 1'b0;
        wait_until(c0 + 99);
        check("clr_led_before", 32'(led), 32'hA3);
        wait_until(c0 + 101);
        key_clr_n = 1'b1;
        check("clr_running", 32'(running), 0);
        check("clr_led", 32'(led), 0);
        check("clr_addr", 32'(mem_addr), 0);
        check("clr_dir_kept", 32'(dir_down), 1);
        check("clr_speed_kept", 32'(speed), 0);
        wait_until(c0 + 103);
        check("clr_led_stays", 32'(led), 0);

        // restart descending, then reset mid-run
        wait_until(c0 + 104);
        expect_rd(0, c0 + 106, 1'b1);
        expect_rd(3, c0 + 110, 1'b1);
        expect_rd(2, c0 + 114, 1'b1);
        key_run_n = 1'b0;
        wait_until(c0 + 107);
        key_run_n = 1'b1;
        wait_until(c0 + 118);
        rst_n = 1'b0;
        #1;
        check("arst_led", 32'(led), 0);
        check("arst_running", 32'(running), 0);
        check("arst_mem_rd", 32'(mem_rd), 0);
        check("arst_addr", 32'(mem_addr), 0);
        check("arst_dir", 32'(dir_down), 0);
        check("arst_speed", 32'(speed), 0);
        repeat (3) @(posedge clk50m);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk50m);
        #1;
        check("post_rst_running", 32'(running), 0);
        check("rd_queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
